// File: rtl/rf_wb_arbiter_pkg.sv
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared register-file constants, write-back request type and
//               one-hot register mask helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr;
        logic [REG_DATA_W-1:0] wd;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
        reg_mask = NUM_REGS'(1) << r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Write-back requester bus plus registered RF write port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
    parameter int NREQ = 3
) ();
    import rf_wb_arbiter_pkg::*;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*REG_ADDR_W-1:0] req_wr;
    logic [NREQ*REG_DATA_W-1:0] req_wd;
    logic [NREQ-1:0]            req_ready;
    logic                       rf_we;
    logic [REG_ADDR_W-1:0]      rf_wr;
    logic [REG_DATA_W-1:0]      rf_wd;

    modport slave (
        input  req_valid, req_wr, req_wd,
        output req_ready, rf_we, rf_wr, rf_wd
    );

    modport master (
        output req_valid, req_wr, req_wd,
        input  req_ready, rf_we, rf_wr, rf_wd
    );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Parameterised round-robin arbiter; search starts one past the
//               last granted index, pointer moves only on a grant.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [NREQ-1:0]  req_i,
    output logic      [NREQ-1:0]  gnt_o,
    output logic                  gnt_valid_o,
    output logic      [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand_idx;
    int               cand;

    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = last_q;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_q) + k) % NREQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_valid_o && req_i[cand_idx]) begin
                gnt_valid_o     = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                gnt_idx_o       = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q <= IDX_W'(NREQ - 1);
        end else if (gnt_valid_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Round-robin RF write-port arbiter with registered write command
//               and 32-entry pending-write scoreboard. Optional decode bypass
//               enabled by macro RF_WB_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    rf_wb_arbiter_if.slave             bus,
    input  wire logic                  issue_valid_i,
    input  wire logic [REG_ADDR_W-1:0] issue_rd_i,
    output logic                       issue_ready_o,
    input  wire logic [REG_ADDR_W-1:0] rs1_i,
    input  wire logic [REG_ADDR_W-1:0] rs2_i,
    output logic                       raw_hazard_o
`ifdef RF_WB_BYPASS_EN
    ,
    output logic                       byp1_valid_o,
    output logic [REG_DATA_W-1:0]      byp1_data_o,
    output logic                       byp2_valid_o,
    output logic [REG_DATA_W-1:0]      byp2_data_o
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_req_t               req_a [NREQ];
    wb_req_t               sel;
    logic                  xfer;
    logic [IDX_W-1:0]      gnt_idx;
    logic [NUM_REGS-1:0]   busy_q, busy_d, busy_eff;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_wr_q, rf_wr_d;
    logic [REG_DATA_W-1:0] rf_wd_q, rf_wd_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_a[i].wr = bus.req_wr[REG_ADDR_W*i +: REG_ADDR_W];
        assign req_a[i].wd = bus.req_wd[REG_DATA_W*i +: REG_DATA_W];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req_valid),
        .gnt_o       (bus.req_ready),
        .gnt_valid_o (xfer),
        .gnt_idx_o   (gnt_idx)
    );

    assign sel = req_a[gnt_idx];

    // r0 transfers complete the handshake but never reach the RF
    always_comb begin
        rf_we_d = xfer && (sel.wr != '0);
        rf_wr_d = rf_we_d ? sel.wr : rf_wr_q;
        rf_wd_d = rf_we_d ? sel.wd : rf_wd_q;
    end

    assign issue_ready_o = !busy_q[issue_rd_i];

    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d = busy_d & ~reg_mask(sel.wr);
        end
        if (issue_valid_i && issue_ready_o && (issue_rd_i != '0)) begin
            busy_d = busy_d | reg_mask(issue_rd_i);
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q  <= '0;
            rf_we_q <= 1'b0;
            rf_wr_q <= '0;
            rf_wd_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            rf_wr_q <= rf_wr_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_wr = rf_wr_q;
    assign bus.rf_wd = rf_wd_q;

`ifdef RF_WB_BYPASS_EN
    // A register being written back this cycle is readable via the bypass next cycle
    assign busy_eff     = busy_q & ~(xfer ? reg_mask(sel.wr) : '0);
    assign byp1_valid_o = rf_we_q && (rf_wr_q == rs1_i) && (rs1_i != '0);
    assign byp2_valid_o = rf_we_q && (rf_wr_q == rs2_i) && (rs2_i != '0);
    assign byp1_data_o  = rf_wd_q;
    assign byp2_data_o  = rf_wd_q;
`else
    assign busy_eff = busy_q;
`endif

    assign raw_hazard_o = busy_eff[rs1_i] | busy_eff[rs2_i];

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Scoreboard bench for rf_wb_arbiter (round-robin, scoreboard,
//               registered write command, reset, optional bypass).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int NREQ = 3;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic        raw_hazard;
`ifdef RF_WB_BYPASS_EN
    logic        byp1_valid, byp2_valid;
    logic [31:0] byp1_data, byp2_data;
`endif

    logic [4:0]  t_wr [NREQ];
    logic [31:0] t_wd [NREQ];

    // reference model state
    logic [31:0] m_busy;
    int          m_last;
    logic        m_rf_we;
    logic [4:0]  m_rf_wr;
    logic [31:0] m_rf_wd;
    exp_t        sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .raw_hazard_o  (raw_hazard)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp1_valid_o  (byp1_valid),
        .byp1_data_o   (byp1_data),
        .byp2_valid_o  (byp2_valid),
        .byp2_data_o   (byp2_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (m_last + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = '0;
        m_last  = NREQ - 1;
        m_rf_we = 1'b0;
        m_rf_wr = '0;
        m_rf_wd = '0;
    endtask

    // One clock cycle: drive, check combinational outputs, push expected write,
    // clock, then pop and check the registered write command.
    task automatic cycle(input logic rstn, input logic [NREQ-1:0] v, input logic iv,
                         input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
        int               g;
        logic [NREQ-1:0]  exp_rdy;
        logic [31:0]      clr;
        logic [31:0]      eff;
        logic             exp_ir;
        exp_t             e, got;

        rst             = rstn;
        bus.req_valid   = v;
        issue_valid     = iv;
        issue_rd        = ird;
        rs1             = r1;
        rs2             = r2;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_wr[5*i +: 5]   = t_wr[i];
            bus.req_wd[32*i +: 32] = t_wd[i];
        end
        #1;
        g       = model_grant(v);
        exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
        exp_ir  = !m_busy[ird];
        clr     = (g >= 0) ? (32'd1 << t_wr[g]) : 32'd0;
`ifdef RF_WB_BYPASS_EN
        eff = m_busy & ~clr;
        chk("byp1_valid", 64'(byp1_valid), 64'(m_rf_we && m_rf_wr == r1 && r1 != 0));
        chk("byp2_valid", 64'(byp2_valid), 64'(m_rf_we && m_rf_wr == r2 && r2 != 0));
        if (m_rf_we && m_rf_wr == r2 && r2 != 0) chk("byp2_data", 64'(byp2_data), 64'(m_rf_wd));
        if (m_rf_we && m_rf_wr == r1 && r1 != 0) chk("byp1_data", 64'(byp1_data), 64'(m_rf_wd));
`else
        eff = m_busy;
`endif
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("issue_ready", 64'(issue_ready), 64'(exp_ir));
        chk("raw_hazard", 64'(raw_hazard), 64'(eff[r1] | eff[r2]));

        if (!rstn) begin
            model_reset();
            e = '{we: 1'b0, wr: 5'd0, wd: 32'd0, chk_data: 1'b1};
        end else begin
            if (g >= 0) begin
                m_last = g;
                m_busy = m_busy & ~clr;
            end
            if (iv && exp_ir && ird != 0) m_busy[ird] = 1'b1;
            m_busy[0] = 1'b0;
            m_rf_we = (g >= 0) && (t_wr[g] != 0);
            if (m_rf_we) begin
                m_rf_wr = t_wr[g];
                m_rf_wd = t_wd[g];
            end
            e = '{we: m_rf_we, wr: m_rf_wr, wd: m_rf_wd, chk_data: (m_rf_we || g < 0)};
        end
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            chk("rf_we", 64'(bus.rf_we), 64'(got.we));
            if (got.chk_data) begin
                chk("rf_wr", 64'(bus.rf_wr), 64'(got.wr));
                chk("rf_wd", 64'(bus.rf_wd), 64'(got.wd));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            t_wr[i] = 5'(10 + i);
            t_wd[i] = 32'h100 + i;
        end
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_wd    = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset values through the scoreboard
        cycle(1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);

        // round-robin order 001, 010, 100 from reset
        repeat (3) cycle(1'b1, 3'b111, 1'b0, 5'd0, 5'd0, 5'd0);

        // RAW/WAW on r5, then requester 2 retires it
        cycle(1'b1, 3'b000, 1'b1, 5'd5, 5'd0, 5'd0);
        cycle(1'b1, 3'b000, 1'b1, 5'd5, 5'd5, 5'd0);
        t_wr[2] = 5'd5; t_wd[2] = 32'hDEADBEEF;
        cycle(1'b1, 3'b100, 1'b0, 5'd0, 5'd5, 5'd0);
        cycle(1'b1, 3'b000, 1'b1, 5'd5, 5'd5, 5'd5);

        // r0 write: handshake completes, no RF write
        t_wr[0] = 5'd0; t_wd[0] = 32'h1234;
        cycle(1'b1, 3'b001, 1'b0, 5'd0, 5'd5, 5'd0);
        cycle(1'b1, 3'b000, 1'b0, 5'd0, 5'd5, 5'd0);

        // simultaneous set r7 and clear r3
        cycle(1'b1, 3'b000, 1'b1, 5'd3, 5'd0, 5'd0);
        t_wr[1] = 5'd3; t_wd[1] = 32'h33;
        cycle(1'b1, 3'b010, 1'b1, 5'd7, 5'd3, 5'd0);
        cycle(1'b1, 3'b000, 1'b0, 5'd0, 5'd7, 5'd0);
        cycle(1'b1, 3'b000, 1'b0, 5'd0, 5'd3, 5'd0);

        // bypass window on r9
        cycle(1'b1, 3'b000, 1'b1, 5'd9, 5'd0, 5'd0);
        t_wr[0] = 5'd9; t_wd[0] = 32'hCAFE0001;
        cycle(1'b1, 3'b001, 1'b0, 5'd0, 5'd0, 5'd9);
        cycle(1'b1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd9);

        // reset the cycle after a grant, and reset during a grant
        t_wr[1] = 5'd12; t_wd[1] = 32'hABCD;
        cycle(1'b1, 3'b010, 1'b1, 5'd20, 5'd0, 5'd0);
        cycle(1'b0, 3'b000, 1'b0, 5'd0, 5'd20, 5'd0);
        cycle(1'b1, 3'b111, 1'b0, 5'd0, 5'd20, 5'd0);
        cycle(1'b0, 3'b110, 1'b1, 5'd21, 5'd0, 5'd0);
        cycle(1'b1, 3'b110, 1'b0, 5'd0, 5'd21, 5'd0);

        // random traffic
        for (int n = 0; n < 60; n++) begin
            logic [4:0] rd;
            logic       iv;
            for (int i = 0; i < NREQ; i++) begin
                t_wr[i] = 5'($urandom_range(0, 15));
                t_wd[i] = $urandom;
            end
            rd = 5'($urandom_range(0, 15));
            iv = 1'($urandom_range(0, 1));
            for (int i = 0; i < NREQ; i++) if (t_wr[i] == rd) iv = 1'b0;
            cycle(1'b1, NREQ'($urandom_range(0, 7)), iv, rd,
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port among NREQ write-back requesters (ALU, load unit, mul/div unit) using round-robin arbitration with valid/ready handshakes. Drives a registered write command (rf_we/rf_wr/rf_wd) into the RF write port. Also keeps a 32-entry pending-write scoreboard, so the decode stage can stall on RAW and WAW hazards against in-flight multi-cycle results.

## Interface
- NREQ, 3, number of write-back requesters (2..4); index 0 is the initial highest priority.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  NREQ  requester i presents a write.
- req_wr  in  NREQ*5  destination register of requester i, packed at bits [5i+4:5i].
- req_wd  in  NREQ*32  write data of requester i, packed at bits [32i+31:32i].
- req_ready  out  NREQ  one-hot or zero; the grant, which completes the handshake in this cycle.
- rf_we  out  1  registered RF write enable.
- rf_wr  out  5  registered RF write address.
- rf_wd  out  32  registered RF write data.
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  5  destination register of the issuing instruction.
- issue_ready  out  1  issue accepted; low while issue_rd is busy (WAW).
- rs1, rs2  in  5 each  source registers of the decoding instruction.
- raw_hazard  out  1  rs1 or rs2 (nonzero) is busy.

## Operation
- Arbitration:
  - Round-robin over req_valid, starting the search at (last_grant+1) mod NREQ.
  - At most one req_ready bit is high per cycle; it is high only for a valid requester.
  - Arbitration is combinational from req_valid and the pointer. There is no backpressure from the RF, so some valid requester is always granted.
  - last_grant updates to the granted index only on a grant.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A requester holds req_valid, req_wr and req_wd stable until granted.
- Write command, registered on the next edge:
  - On a transfer with wr != 0: rf_we=1, rf_wr=wr, rf_wd=wd.
  - On a transfer with wr == 0: the transfer completes but rf_we=0 (r0 is never written).
  - With no transfer: rf_we=0; rf_wr and rf_wd hold their values.
- Scoreboard (busy[31:0], busy[0] hardwired to 0):
  - Set: issue_valid && issue_ready && issue_rd != 0 sets busy[issue_rd].
  - Clear: a transfer to wr clears busy[wr].
  - issue_ready = !busy[issue_rd]. The same register therefore can never be set and cleared in one cycle; a clear and a different-register set may coincide.
  - raw_hazard = busy[rs1] | busy[rs2], combinational.
  - The scoreboard does not check that write-backs were announced. A transfer to a non-busy register just writes the RF.
- Reset (rst=0 at the edge):
  - busy = 0, last_grant = NREQ-1 (so requester 0 wins first), rf_we=0, rf_wr=0, rf_wd=0.
  - A reset mid-transfer discards the pending registered write.

## Timing
- Grant-to-RF latency: 1 cycle. A transfer in cycle N gives rf_we=1 in cycle N+1, and the RF captures at the end of N+1.
- Busy clears at the end of cycle N. A consumer that sees raw_hazard=0 in cycle N+1 reads through the RF in N+1 and gets the old value until the N+1 edge. Decode must add one extra stall cycle, or the bypass must be enabled (see Configuration).
- Throughput: one write per cycle. A requester that stays valid waits at most NREQ-1 cycles.
- req_ready, issue_ready and raw_hazard are combinational from the inputs and the current state, with no registered delay.

## Configuration
- RF_WB_BYPASS_EN defined:
  - raw_hazard additionally ignores a busy register whose write is in the current transfer.
  - Outputs byp1_valid/byp1_data and byp2_valid/byp2_data (1/32 bits) return the in-flight rf_wd when rf_we && rf_wr == rs1/rs2 (nonzero), so decode can use the value in cycle N+1 without a stall.
- Undefined: the bypass ports are absent and raw_hazard follows the pure busy formula above.

## Structure
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 constants, and the wb_req_t struct (wr, wd).
- One sub-module, rr_arbiter: parameterised NREQ round-robin with req, grant and pointer update. It is reusable for memory-port sharing.
- Scoreboard, output register and bypass logic live in the top module.

## Test plan
- Reset then req_valid=3'b111 held for 3 cycles → grants 001, 010, 100 in order; rf_wr follows each requester's wr one cycle later.
- Issue rd=5 → busy[5]=1; rs1=5 gives raw_hazard=1; second issue rd=5 → issue_ready=0; requester 2 writes r5=32'hDEADBEEF → busy clears, and rf_we/rf_wr=5/rf_wd=DEADBEEF appear next cycle.
- Request with wr=0, wd=32'h1234 → req_ready high, rf_we stays 0, and busy is unchanged.
- Same cycle: issue rd=7 and transfer to r3 (busy) → busy[7]=1 and busy[3]=0 after the edge.
- rst=0 asserted the cycle after a grant → rf_we=0 the next cycle, all busy bits cleared, first post-reset grant goes to requester 0.
- With RF_WB_BYPASS_EN: transfer r9=32'hCAFE0001 in cycle N, rs2=9 in N+1 → byp2_valid=1, byp2_data=CAFE0001, raw_hazard=0.
